// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM state codes
// and the parity helper used by both the transmit and receive paths.
// Ports: none (package).
package uart_pkg;

  // Parity mode selectors.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Transmit FSM states.
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // Receive FSM states.
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // Parity bit for a data word (zero-extended to 9 bits, so unused upper
  // bits do not affect the result).
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~(^data);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling FSM.
// Latency: rx_valid at the stop-bit mid-sample, 3 + bits*CLKS_PER_BIT + CLKS_PER_BIT/2 after line falls.
// Backpressure: none; every completed frame is reported as a one-cycle pulse.
// Ports: serial_in (async serial input), rx_data/rx_valid/rx_parity_err/rx_frame_err, busy (FSM not idle).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 busy
);

  localparam int         CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int         BIT_W     = $clog2(DATA_BITS);
  localparam logic [1:0] PMODE     = 2'(PARITY);
  localparam bit         HAS_PAR   = (PMODE != PAR_NONE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_BITS - 1);

  logic                 sync1, sync2, prev;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_rx;

  // Synchroniser and edge-detect flops preset to idle-high so a reset never
  // looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_rx        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (prev && !sync2) state <= RX_START;
        end
        RX_START: begin
          // A line back high at mid start bit was a glitch: drop silently.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            if (bit_idx == WORD_LAST) state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else                      bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt    <= '0;
            par_rx <= sync2;
            state  <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt           <= '0;
            state         <= RX_IDLE;
            rx_valid      <= 1'b1;
            rx_data       <= shreg;
            rx_parity_err <= HAS_PAR && (par_rx != parity_bit(9'(shreg), PMODE));
            rx_frame_err  <= ~sync2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver: TX FSM, loopback mux into the receiver core, combined busy.
// Latency: tx_line drops the cycle after the handshake; loopback rx_valid follows the frame's stop mid-sample.
// Backpressure: tx_ready is high only while TX is idle; one idle-high cycle separates back-to-back frames.
// Ports: tx_data/tx_valid/tx_ready/tx_line (transmit), rx_line/loopback (receive source),
//        rx_data/rx_valid/rx_parity_err/rx_frame_err (receive result), busy.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_line,
  input  logic                 rx_line,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 busy
);

  localparam int         CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int         BIT_W   = $clog2(DATA_BITS);
  localparam logic [1:0] PMODE   = 2'(PARITY);
  localparam bit         HAS_PAR = (PMODE != PAR_NONE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_BITS - 1);

  logic [2:0]           tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 rx_busy;

  // Held low during reset so no word is accepted in the reset cycle.
  assign tx_ready = (tx_state == TX_IDLE) && !rst;

  // tx_line is registered so the line never glitches between bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          tx_cnt  <= '0;
          if (tx_valid) begin
            tx_shreg <= tx_data;
            tx_par   <= parity_bit(9'(tx_data), PMODE);
            tx_line  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shreg[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == WORD_LAST) begin
              tx_line  <= HAS_PAR ? tx_par : 1'b1;
              tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shreg <= tx_shreg >> 1;
              tx_line  <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_line  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  uart_rx_core #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (loopback ? tx_line : rx_line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .busy         (rx_busy)
  );

  assign busy = (tx_state != TX_IDLE) || rx_busy;

endmodule

// File: tb/tb_uart_transceiver.sv
module tb_uart_transceiver;

  localparam int DB  = 8;
  localparam int CPB = 16;
  localparam int PAR = 1;
  localparam int PB  = (PAR != 0) ? 1 : 0;
  localparam int NB  = 1 + DB + PB + 1;
  localparam int LAT = 3 + (1 + DB + PB) * CPB + CPB / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tx_valid, tx_ready, tx_line, rx_line, loopback;
  logic [DB-1:0] tx_data, rx_data;
  logic          rx_valid, rx_parity_err, rx_frame_err, busy;

  // Second instance with odd parity listens to the same external line.
  logic [DB-1:0] tx_data2 = '0;
  logic          tx_valid2 = 1'b0, loopback2 = 1'b0;
  logic          tx_ready2, tx_line2, rx_valid2, rx_parity_err2, rx_frame_err2, busy2;
  logic [DB-1:0] rx_data2;

  uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PAR)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_line(tx_line), .rx_line(rx_line), .loopback(loopback), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .busy(busy)
  );

  uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(2)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_line(tx_line2), .rx_line(rx_line), .loopback(loopback2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_parity_err(rx_parity_err2), .rx_frame_err(rx_frame_err2), .busy(busy2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
    int            when;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  exp_t e1, e2;

  // Reference parity from the count of ones: mode 1 = even, 2 = odd.
  function automatic logic model_par(input logic [DB-1:0] d, input int mode);
    int ones;
    ones = $countones(d);
    if (mode == 1) return (ones % 2) == 1;
    if (mode == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Expected serial frame, index 0 = first bit on the wire.
  function automatic logic [NB-1:0] frame_bits(input logic [DB-1:0] d);
    logic [NB-1:0] f;
    f = '0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
    if (PAR != 0) f[1+DB] = model_par(d, PAR);
    f[NB-1] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (sb.size() == 0) chk("rx_valid_unexpected", 1, 0);
      else begin
        e1 = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e1.d));
        chk("rx_parity_err", 32'(rx_parity_err), 32'(e1.pe));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(e1.fe));
        if (e1.when >= 0) chk("rx_latency_cycle", cyc, e1.when);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rx_valid2) begin
      if (sb2.size() == 0) chk("odd_rx_valid_unexpected", 1, 0);
      else begin
        e2 = sb2.pop_front();
        chk("odd_rx_data", 32'(rx_data2), 32'(e2.d));
        chk("odd_rx_parity_err", 32'(rx_parity_err2), 32'(e2.pe));
        chk("odd_rx_frame_err", 32'(rx_frame_err2), 32'(e2.fe));
      end
    end
  end

  // Transmit one word through the handshake and check the wire cycle by cycle.
  // Called at a negedge; returns at the negedge after the last stop cycle.
  task automatic send(input logic [DB-1:0] d, input bit hold);
    int n;
    int bad_line;
    int bad_rdy;
    logic [NB-1:0] fb;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("tx_ready_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    sb.push_back('{d: d, pe: 1'b0, fe: 1'b0, when: cyc + LAT});
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data  = DB'($urandom);
    end
    fb = frame_bits(d);
    bad_rdy = 0;
    for (int b = 0; b < NB; b++) begin
      bad_line = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_line !== fb[b]) bad_line++;
        if (tx_ready !== 1'b0) bad_rdy++;
        @(negedge clk);
      end
      chk($sformatf("tx_line_bit%0d_bad_cycles", b), bad_line, 0);
    end
    chk("tx_ready_in_frame_bad_cycles", bad_rdy, 0);
    chk("tx_ready_after_frame", 32'(tx_ready), 1);
    chk("tx_line_idle_after_frame", 32'(tx_line), 1);
  endtask

  // Drive one frame on the external line, then one idle-high bit.
  task automatic ext_frame(input logic [DB-1:0] d, input logic p, input logic stop);
    sb.push_back('{d: d, pe: (p != model_par(d, 1)), fe: ~stop, when: -1});
    sb2.push_back('{d: d, pe: (p != model_par(d, 2)), fe: ~stop, when: -1});
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_line = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = p;
    repeat (CPB) @(negedge clk);
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sb2.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    logic [DB-1:0] d;
    logic p;
    logic s;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_line = 1'b1; loopback = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_line", 32'(tx_line), 1);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_parity_err", 32'(rx_parity_err), 0);
    chk("rst_rx_frame_err", 32'(rx_frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tx_ready_after_rst", 32'(tx_ready), 1);

    // Loopback single word.
    send(8'hA5, 1'b0);
    drain();

    // Held valid: back-to-back frames.
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b0);
    drain();

    // Short external glitch must be rejected as a start bit.
    loopback = 1'b0;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    chk("glitch_busy_seen", 32'(saw_busy), 1);
    chk("glitch_busy_cleared", 32'(busy), 0);

    // External frames: bad parity, bad stop, then a clean frame.
    ext_frame(8'h81, 1'b1, 1'b1);
    ext_frame(8'h55, model_par(8'h55, 1), 1'b0);
    ext_frame(8'h12, model_par(8'h12, 1), 1'b1);
    drain();

    // Reset in the middle of data bit 3 of a loopback frame.
    loopback = 1'b1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_line", 32'(tx_line), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_ready_in_rst", 32'(tx_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_ready_after", 32'(tx_ready), 1);
    chk("midrst_busy_after", 32'(busy), 0);
    send(8'h0F, 1'b0);
    drain();

    // Randomized loopback traffic, some back-to-back.
    for (int i = 0; i < 6; i++) begin
      d = DB'($urandom);
      send(d, (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    drain();

    // Randomized external frames with occasional parity/stop errors.
    loopback = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = DB'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~model_par(d, 1) : model_par(d, 1);
      s = ($urandom_range(0, 3) != 0);
      ext_frame(d, p, s);
    end
    drain();
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    chk("odd_scoreboard_empty", sb2.size(), 0);
    chk("final_busy", 32'(busy), 0);
    chk("odd_idle_tx_line", 32'(tx_line2), 1);
    chk("odd_idle_tx_ready", 32'(tx_ready2), 1);
    chk("odd_idle_busy", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
